// File: rtl/mux_441.sv
`default_nettype none
// ============================================================================
//  Module      : mux_441
//  Description : Registered 4:1 multiplexer with capture enable. The selected
//                input is loaded into the output register on enabled edges;
//                the select that produced it, a one-cycle "value changed"
//                pulse and the even parity of the held value are also
//                provided. Every output comes from a register (parity is a
//                pure function of the output register), so there is no
//                combinational path from any input to any output.
//  Ports       :
//      clk  in   1      single clock, all state updates on rising edge
//      rst  in   1      synchronous active-high reset (priority over en)
//      en   in   1      capture enable: 1 = load I[s], 0 = hold
//      s    in   2      select: 0->I0, 1->I1, 2->I2, 3->I3
//      I0..I3 in WIDTH  data inputs
//      O    out  WIDTH  registered selected data
//      s_q  out  2      registered select that produced O
//      chg  out  1      one-cycle pulse: O changed value on the last edge
//      par  out  1      even parity (XOR reduction) of O
//  Revision    : 1.0  initial release
// ============================================================================
module mux_441 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    output logic [WIDTH-1:0] O,
    output logic [1:0]       s_q,
    output logic             chg,
    output logic             par
);

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_o;
    logic [1:0]       r_s_q;
    logic             r_chg;

    // Fully decoded select; the default arm only keeps the block latch-free
    // should the select ever carry X in simulation.
    always_comb begin
        w_sel = '0;
        case (s)
            2'd0:    w_sel = I0;
            2'd1:    w_sel = I1;
            2'd2:    w_sel = I2;
            2'd3:    w_sel = I3;
            default: w_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o   <= '0;
            r_s_q <= 2'd0;
            r_chg <= 1'b0;
        end else begin
            // Pulse only when a load actually alters the held value; a new
            // select that yields identical data does not count as a change.
            r_chg <= en && (w_sel != r_o);
            if (en) begin
                r_o   <= w_sel;
                r_s_q <= s;
            end
        end
    end

    assign O   = r_o;
    assign s_q = r_s_q;
    assign chg = r_chg;
    // Derived from the output register only, never from the data inputs.
    assign par = ^r_o;

endmodule
`default_nettype wire

// File: tb/tb_mux_441.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_441
//  Description : Self-checking bench for mux_441. Directed scenarios followed
//                by randomized traffic, checked against a behavioural model.
//                Each step drives junk inputs after the falling edge, checks
//                that outputs are unaffected, then applies the real inputs
//                shortly before the rising edge and checks the result.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_441;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       s;
    logic [WIDTH-1:0] I0, I1, I2, I3;
    logic [WIDTH-1:0] O;
    logic [1:0]       s_q;
    logic             chg;
    logic             par;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [WIDTH-1:0] m_o   = '0;
    logic [1:0]       m_sq  = 2'd0;
    logic             m_chg = 1'b0;

    always #5 clk = ~clk;

    mux_441 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .s   (s),
        .I0  (I0),
        .I1  (I1),
        .I2  (I2),
        .I3  (I3),
        .O   (O),
        .s_q (s_q),
        .chg (chg),
        .par (par)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_par;
        exp_par = ($countones(m_o) % 2) == 1;
        check({tag, ".O"},   32'(O),   32'(m_o));
        check({tag, ".s_q"}, 32'(s_q), 32'(m_sq));
        check({tag, ".chg"}, 32'(chg), 32'(m_chg));
        check({tag, ".par"}, 32'(par), 32'(exp_par));
    endtask

    // One clock edge: junk inputs between edges, real inputs just before the
    // rising edge, then model update and comparison.
    task automatic step(input string tag, input logic r, input logic e, input logic [1:0] sel,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] v [4];
        @(negedge clk);
        rst = 1'b0;
        en  = 1'($urandom);
        s   = 2'($urandom);
        I0  = WIDTH'($urandom);
        I1  = WIDTH'($urandom);
        I2  = WIDTH'($urandom);
        I3  = WIDTH'($urandom);
        #1;
        check_all({tag, "_between"});
        #2;
        rst = r; en = e; s = sel;
        I0 = a; I1 = b; I2 = c; I3 = d;
        @(posedge clk);
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        if (r) begin
            m_o = '0; m_sq = 2'd0; m_chg = 1'b0;
        end else if (e) begin
            m_chg = (v[sel] != m_o);
            m_o   = v[sel];
            m_sq  = sel;
        end else begin
            m_chg = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; s = 2'd2;
        I0 = 4'h9; I1 = 4'h9; I2 = 4'h9; I3 = 4'h9;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // Select sweep, twice
        for (int k = 0; k < 8; k++)
            step("sweep", 1'b0, 1'b1, 2'(k % 4), 4'h1, 4'h2, 4'h3, 4'h4);

        // Alternating data: s=3, then 0..3
        step("alt", 1'b0, 1'b1, 2'd3, 4'h5, 4'hA, 4'h5, 4'hA);
        for (int k = 0; k < 4; k++)
            step("alt", 1'b0, 1'b1, 2'(k), 4'h5, 4'hA, 4'h5, 4'hA);

        // Same-value select change
        step("same0", 1'b0, 1'b1, 2'd0, 4'h5, 4'h3, 4'h5, 4'hC);
        step("same2", 1'b0, 1'b1, 2'd2, 4'h5, 4'h3, 4'h5, 4'hC);

        // Hold with toggling inputs
        for (int k = 0; k < 5; k++)
            step("hold", 1'b0, 1'b0, 2'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                 WIDTH'($urandom), WIDTH'($urandom));

        // Reset mid-operation with en=1 and data present
        step("pre_rst", 1'b0, 1'b1, 2'd3, 4'h1, 4'h2, 4'h3, 4'h4);
        step("rst_mid", 1'b1, 1'b1, 2'd1, 4'h1, 4'h2, 4'h3, 4'h4);
        step("post_rst", 1'b0, 1'b1, 2'd1, 4'h1, 4'h2, 4'h3, 4'h4);

        // Parity
        step("par1", 1'b0, 1'b1, 2'd0, 4'h1, 4'h0, 4'h0, 4'h0);
        step("par3", 1'b0, 1'b1, 2'd0, 4'h3, 4'h0, 4'h0, 4'h0);
        step("par7", 1'b0, 1'b1, 2'd0, 4'h7, 4'h0, 4'h0, 4'h0);

        // Randomized traffic
        for (int k = 0; k < 300; k++)
            step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                 WIDTH'($urandom), WIDTH'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
